// File: rtl/as_gpio_wr_sequencer.sv
// GPIO write sequencer: buffers store requests in a small FIFO and replays each
// one on the GPIO pins with programmable setup/hold and a one-cycle chip select.
module as_gpio_wr_sequencer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_W-1:0]             req_addr_i,
  input  logic [DATA_W-1:0]             req_data_i,
  output logic [DATA_W-1:0]             gpio_o,
  output logic [ADDR_W-1:0]             gpioAddr_o,
  output logic                          cs_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [3:0] SETUP_LD = 4'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [3:0] HOLD_LD  = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  // One-hot state encoding; each bit index names a state flop.
  localparam int S_IDLE   = 0;
  localparam int S_SETUP  = 1;
  localparam int S_STROBE = 2;
  localparam int S_HOLD   = 3;

  typedef logic [3:0] state_t;
  localparam state_t IDLE   = 4'b0001;
  localparam state_t SETUP  = 4'b0010;
  localparam state_t STROBE = 4'b0100;
  localparam state_t HOLD   = 4'b1000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             reload_slot;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push    = req_valid_i && !full;
  assign level_o = level;

  // NOTE: storage array carries no reset; only pointers and level define
  // which entries are valid, so flushing them is enough.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: req_addr_i, data: req_data_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A "reload slot" is any cycle that behaves like IDLE:
  // the head word may be popped and launched straight into its setup phase.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reload_slot) begin
      if (!empty) begin
        state_d = (SETUP_CYC > 0) ? SETUP : STROBE;
        cnt_d   = SETUP_LD;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (state_q[S_SETUP]) begin
      if (cnt_q == '0) state_d = STROBE;
      else             cnt_d   = cnt_q - 4'd1;
    end else if (state_q[S_STROBE]) begin
      state_d = HOLD;
      cnt_d   = HOLD_LD;
    end else if (state_q[S_HOLD]) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Output decode.
  always_comb begin
    reload_slot = state_q[S_IDLE]
               || (state_q[S_STROBE] && (HOLD_CYC == 0))
               || (state_q[S_HOLD] && (cnt_q == '0));
    pop         = reload_slot && !empty;
    cs_o        = state_q[S_STROBE];
    busy_o      = !state_q[S_IDLE] || !empty;
    req_ready_o = !full;
  end

  // Pin registers change only when a word is popped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gpio_o     <= '0;
      gpioAddr_o <= '0;
    end else if (pop) begin
      gpio_o     <= mem[rd_ptr].data;
      gpioAddr_o <= mem[rd_ptr].addr;
    end
  end

endmodule

// File: tb/tb_as_gpio_wr_sequencer.sv
// Self-checking bench: default-timing instance plus a zero setup/hold instance,
// with a scoreboard of accepted words compared at every chip-select pulse.
module tb_as_gpio_wr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       d_valid, d_ready, d_cs, d_busy;
  logic [7:0] d_addr, d_data, d_gpio, d_gaddr;
  logic [2:0] d_level;

  logic       z_valid, z_ready, z_cs, z_busy;
  logic [7:0] z_addr, z_data, z_gpio, z_gaddr;
  logic [2:0] z_level;

  as_gpio_wr_sequencer dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(d_valid), .req_ready_o(d_ready),
    .req_addr_i(d_addr), .req_data_i(d_data),
    .gpio_o(d_gpio), .gpioAddr_o(d_gaddr), .cs_o(d_cs),
    .busy_o(d_busy), .level_o(d_level)
  );

  as_gpio_wr_sequencer #(.SETUP_CYC(0), .HOLD_CYC(0)) dut_z (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(z_valid), .req_ready_o(z_ready),
    .req_addr_i(z_addr), .req_data_i(z_data),
    .gpio_o(z_gpio), .gpioAddr_o(z_gaddr), .cs_o(z_cs),
    .busy_o(z_busy), .level_o(z_level)
  );

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] d_sb[$];
  logic [15:0] z_sb[$];
  logic [15:0] d_exp, z_exp;
  logic [15:0] d_prev_pins;
  logic        d_prev_cs = 1'b0;
  int          d_max_level = 0;
  int          z_run = 0;
  int          z_max_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard, sampled mid-cycle. Strobes are checked before new
  // handshakes are recorded so a stray strobe can never consume a fresh word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_cs) begin
        if (d_sb.size() == 0) check("d_stray_strobe", 32'd1, 32'd0);
        else begin
          d_exp = d_sb.pop_front();
          check("d_strobe_pins", 32'({d_gaddr, d_gpio}), 32'(d_exp));
        end
        check("d_setup_stable", 32'(d_prev_pins), 32'({d_gaddr, d_gpio}));
      end
      if (d_prev_cs) check("d_hold_stable", 32'({d_gaddr, d_gpio}), 32'(d_prev_pins));
      if (d_valid && d_ready) d_sb.push_back({d_addr, d_data});
      if (int'(d_level) > d_max_level) d_max_level = int'(d_level);

      if (z_cs) begin
        z_run++;
        if (z_sb.size() == 0) check("z_stray_strobe", 32'd1, 32'd0);
        else begin
          z_exp = z_sb.pop_front();
          check("z_strobe_pins", 32'({z_gaddr, z_gpio}), 32'(z_exp));
        end
      end else begin
        if (z_run > z_max_run) z_max_run = z_run;
        z_run = 0;
      end
      if (z_valid && z_ready) z_sb.push_back({z_addr, z_data});
    end
    d_prev_cs   = rst_n && d_cs;
    d_prev_pins = {d_gaddr, d_gpio};
  end

  logic [11:0] pat;
  int          guard;
  int          strobes;
  logic        seen_stall;

  initial begin
    rst_n = 1'b0;
    d_valid = 1'b0; d_addr = '0; d_data = '0;
    z_valid = 1'b0; z_addr = '0; z_data = '0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_gpio",  32'(d_gpio),  32'h0);
    check("rst_gaddr", 32'(d_gaddr), 32'h0);
    check("rst_cs",    32'(d_cs),    32'h0);
    check("rst_busy",  32'(d_busy),  32'h0);
    check("rst_level", 32'(d_level), 32'h0);
    check("rst_ready", 32'(d_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Single write: accepted at E0, loaded at E1, strobe between E2 and E3.
    d_valid = 1'b1; d_addr = 8'h04; d_data = 8'h01;
    tick();
    d_valid = 1'b0;
    check("single_e0_cs",    32'(d_cs),    32'h0);
    check("single_e0_level", 32'(d_level), 32'h1);
    tick();
    check("single_e1_pins",  32'({d_gaddr, d_gpio}), 32'h0401);
    check("single_e1_cs",    32'(d_cs),    32'h0);
    tick();
    check("single_e2_cs",    32'(d_cs),    32'h1);
    tick();
    check("single_e3_cs",    32'(d_cs),    32'h0);
    check("single_e3_busy",  32'(d_busy),  32'h1);
    tick();
    check("single_e4_busy",  32'(d_busy),  32'h0);
    check("single_e4_pins",  32'({d_gaddr, d_gpio}), 32'h0401);

    // Back-to-back: strobes after E2, E5, E8.
    d_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t < 3) begin
        d_addr = 8'h10 + 8'(t);
        d_data = 8'hA1 + 8'(t);
      end else begin
        d_valid = 1'b0;
      end
      tick();
      pat[t] = d_cs;
    end
    check("b2b_strobe_pattern", 32'(pat), 32'h124);
    check("b2b_busy_done",      32'(d_busy), 32'h0);
    check("b2b_sb_empty",       32'(d_sb.size()), 32'h0);

    // Idle hold: pins keep the last word.
    for (int c = 0; c < 50; c++) begin
      tick();
      check("idle_hold", 32'({d_gaddr, d_gpio, d_cs, d_ready}), {14'h0, 8'h12, 8'hA3, 1'b0, 1'b1});
    end

    // Backpressure: eight words offered with valid held high.
    d_max_level = 0;
    seen_stall  = 1'b0;
    d_valid     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_addr = 8'h20 + 8'(i);
      d_data = 8'h50 + 8'(i);
      guard  = 0;
      while (!d_ready && guard < 20) begin
        tick();
        guard++;
        if (d_ready && !seen_stall) begin
          seen_stall = 1'b1;
          check("bp_reassert_level", 32'(d_level), 32'h3);
        end
      end
      if (guard == 20) check("bp_ready_timeout", 32'd0, 32'd1);
      tick();
      if (i == 5) begin
        check("bp_ready_after6", 32'(d_ready), 32'h0);
        check("bp_level_full",   32'(d_level), 32'h4);
      end
    end
    d_valid = 1'b0;
    guard = 0;
    while (d_busy && guard < 60) begin
      tick();
      guard++;
    end
    check("bp_drain_timeout", 32'(d_busy), 32'h0);
    check("bp_peak_level",    32'(d_max_level), 32'h4);
    check("bp_sb_empty",      32'(d_sb.size()), 32'h0);
    check("bp_seen_stall",    32'(seen_stall), 32'h1);

    // Reset mid-transfer: three words queued, reset while cs_o is high.
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_addr = 8'h30 + 8'(i);
      d_data = 8'h70 + 8'(i);
      tick();
    end
    d_valid = 1'b0;
    guard = 0;
    while (!d_cs && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_cs_seen", 32'(d_cs), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs",    32'(d_cs),    32'h0);
    check("mid_rst_pins",  32'({d_gaddr, d_gpio}), 32'h0);
    check("mid_rst_level", 32'(d_level), 32'h0);
    check("mid_rst_busy",  32'(d_busy),  32'h0);
    check("mid_rst_ready", 32'(d_ready), 32'h1);
    d_sb.delete();
    z_sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (d_cs) strobes++;
    end
    check("mid_no_strobes", 32'(strobes), 32'h0);
    check("mid_level_idle", 32'(d_level), 32'h0);

    // Recovery: a new request after reset is delivered normally.
    d_valid = 1'b1; d_addr = 8'h55; d_data = 8'hAA;
    tick();
    d_valid = 1'b0;
    repeat (6) tick();
    check("recover_pins",     32'({d_gaddr, d_gpio}), 32'h55AA);
    check("recover_sb_empty", 32'(d_sb.size()), 32'h0);

    // Zero setup/hold: four writes give four consecutive strobe cycles.
    z_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z_addr = 8'h40 + 8'(i);
      z_data = 8'h60 + 8'(i);
      tick();
    end
    z_valid = 1'b0;
    repeat (10) tick();
    check("z_consecutive",  32'(z_max_run), 32'h4);
    check("z_cs_low",       32'(z_cs),      32'h0);
    check("z_sb_empty",     32'(z_sb.size()), 32'h0);
    check("z_busy_done",    32'(z_busy),    32'h0);
    check("z_level_empty",  32'(z_level),   32'h0);
    check("z_last_pins",    32'({z_gaddr, z_gpio}), 32'h4363);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/as_gpio_wr_sequencer.md
Name: as_gpio_wr_sequencer

Overview:
Sequencer between the core's memory-mapped GPIO store path and the chip-level GPIO pins gpio_o, gpioAddr_o and cs_o.
- Accepts GPIO write requests over a valid/ready handshake and buffers them in a small FIFO.
- Replays each request on the pins with programmable setup and hold, plus a one-cycle chip-select strobe.
- External devices and the top-level bench sample gpio_o and gpioAddr_o while cs_o is high.

Parameters:
DATA_W, nr_gpios (8), width of gpio_o and req_data_i
ADDR_W, gpio_addr_width (8), width of gpioAddr_o and req_addr_i
FIFO_DEPTH, 4, request buffer entries; power of two, at least 2
SETUP_CYC, 1, cycles addr/data are stable before cs_o rises (0..15)
HOLD_CYC, 1, cycles addr/data are held after cs_o falls (0..15)

Ports:
clk_i  in  1  system clock; all state changes on its rising edge
rst_i  in  1  asynchronous, active-low reset
req_valid_i  in  1  write request present
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o at a rising edge
req_addr_i  in  ADDR_W  GPIO register address
req_data_i  in  DATA_W  GPIO write data
gpio_o  out  DATA_W  registered pin data
gpioAddr_o  out  ADDR_W  registered pin address
cs_o  out  1  registered chip-select strobe
busy_o  out  1  high when FSM is not IDLE or FIFO is non-empty
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i=0, takes effect immediately):
  - gpio_o=0, gpioAddr_o=0, cs_o=0, busy_o=0, level_o=0.
  - FIFO flushed; FSM forced to IDLE; setup/hold counter cleared.
  - req_ready_o=1 once FIFO is empty.
- Reset asserted mid-transfer: cs_o drops asynchronously; the in-flight word and all queued words are discarded.
- FIFO:
  - req_ready_o = !full (combinational from level).
  - Push on each handshake.
  - A push and a pop in the same edge leave level unchanged.
  - No push when full.
  - No same-cycle bypass: a word is always written into the FIFO first.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM, one-hot, states IDLE, SETUP, STROBE, HOLD:
  - IDLE: if FIFO non-empty, pop head and load gpioAddr_o/gpio_o. Go to SETUP (counter=SETUP_CYC-1), or to STROBE if SETUP_CYC=0.
  - SETUP: count down; at 0 go to STROBE.
  - STROBE: lasts exactly one cycle.
    - Next state is HOLD if HOLD_CYC>0 (counter=HOLD_CYC-1).
    - Otherwise behaves like IDLE: pop and reload if FIFO is non-empty, else go to IDLE.
  - HOLD: count down; at 0 behave like IDLE (pop and reload directly into SETUP/STROBE if non-empty, else go to IDLE).
- cs_o is the STROBE state flop; it is high exactly one cycle per word.
- gpio_o and gpioAddr_o change only on a pop edge and are otherwise held, including in IDLE after the last word.
- Latency with defaults:
  - Request accepted at edge E0, load at E1, cs_o high between E2 and E3.
  - Back-to-back throughput is one word per SETUP_CYC+1+HOLD_CYC cycles (3).
- SETUP_CYC=HOLD_CYC=0: cs_o may stay high over consecutive cycles; each high cycle is a distinct word with new addr/data.
- Ordering: strict FIFO; no word is dropped or duplicated.

Test Plan:
- Single write: reset low 10 cycles, then one request addr=0x04 data=0x01.
  - cs_o high for exactly one cycle, 2 edges after acceptance, with gpioAddr_o=0x04 and gpio_o=0x01.
  - Outputs held afterwards; busy_o=0 after the hold cycle.
- Back-to-back: 3 requests on consecutive cycles (0x10/0xA1, 0x11/0xA2, 0x12/0xA3).
  - cs_o pulses spaced 3 cycles apart, in order.
  - Addr/data stable in the cycle before and the cycle after each pulse.
- Backpressure: req_valid_i held high with 8 distinct words (defaults).
  - req_ready_o deasserts after the 6th accepted word; level_o peaks at 4.
  - All accepted words emerge in order; ready re-asserts after the next pop.
- Reset mid-transfer: 3 words queued, rst_i pulled low while cs_o=1.
  - cs_o falls without waiting for a clock edge; all outputs 0; level_o=0.
  - No further strobes after release until new requests arrive.
- Zero-timing config (SETUP_CYC=0, HOLD_CYC=0): 4 consecutive writes.
  - cs_o high for 4 consecutive cycles with a new addr/data each cycle.
  - cs_o then returns to 0.
- Idle hold: no requests for 50 cycles after a transfer.
  - gpio_o/gpioAddr_o keep the last values; cs_o stays 0; req_ready_o stays 1.
